// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   req_id_e   - requester id driven by the grant logic
//   rd_tag_t   - one read-tracking stage {valid, dest}
//   DEF_*      - default memory geometry
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_LD   = 2'd2,
    REQ_ST   = 2'd3
  } req_id_e;

  // dest selects which read port receives the returning data
  localparam logic DEST_IF = 1'b0;
  localparam logic DEST_LD = 1'b1;

  typedef struct packed {
    logic valid;
    logic dest;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: shift register of read tags that follows each read command
// through the memory so the returning word can be steered to its requester.
//   clk, resetn - clock, asynchronous active-low clear (drops reads in flight)
//   tag_in      - tag of the command being registered this edge
//   tag_last    - tag aligned with the cycle in which mem_rdata is valid
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    resetn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_last
);

  // Stage 0 is loaded on the same edge as mem_en, so it is aligned with the
  // command cycle; RD_LAT further shifts line it up with mem_rdata.
  localparam int DEPTH = RD_LAT + 1;

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_last = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF), load (LD) and store (ST). One combinational grant per cycle, a
// registered memory command, and a tag pipeline routing read data back.
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   if_req/if_addr/if_gnt            fetch request, address, accept
//   if_rvalid/if_rdata               fetch return
//   ld_req/ld_addr/ld_gnt            load request, address, accept
//   ld_rvalid/ld_rdata               load return
//   st_req/st_addr/st_wdata/st_gnt   store request and accept
//   mem_en/mem_we/mem_addr/mem_wdata registered memory command
//   mem_rdata                        memory data, RD_LAT cycles after mem_en
//   stall_pipe                       fetch requesting but not granted
//   perf_*_cnt                       grant/conflict counters
//
// Optional feature: define MEM_ARB_PERF_CNT_EN to build the saturating
// performance counters; otherwise the perf outputs are tied to zero.
//
// Handshake: a requester raises req with address/data and holds them stable
// until gnt is seen high in the same cycle; that cycle is the transfer.
// Dropping req before gnt simply withdraws the request. Read data returns
// RD_LAT+1 cycles after gnt with a one-cycle rvalid pulse and no back-pressure.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pipe,
  output logic [15:0]       perf_if_cnt,
  output logic [15:0]       perf_ld_cnt,
  output logic [15:0]       perf_st_cnt,
  output logic [15:0]       perf_conf_cnt
);

  req_id_e    win;
  logic [3:0] starve_q;
  logic       promote;
  rd_tag_t    tag_in;
  rd_tag_t    tag_last;

  // Once fetch has lost STARVE_MAX cycles in a row it jumps to the front.
  assign promote = (starve_q == 4'(STARVE_MAX));

  always_comb begin
    win = REQ_NONE;
    if (promote) begin
      if (if_req)      win = REQ_IF;
      else if (st_req) win = REQ_ST;
      else if (ld_req) win = REQ_LD;
    end else begin
      if (st_req)      win = REQ_ST;
      else if (ld_req) win = REQ_LD;
      else if (if_req) win = REQ_IF;
    end
  end

  assign if_gnt     = (win == REQ_IF);
  assign ld_gnt     = (win == REQ_LD);
  assign st_gnt     = (win == REQ_ST);
  assign stall_pipe = if_req & ~if_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (stall_pipe) begin
      if (!promote) starve_q <= starve_q + 4'd1;
    end else begin
      starve_q <= '0;
    end
  end

  // Command register: address/wdata hold when idle so the bus stays quiet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= (win != REQ_NONE);
      mem_we <= (win == REQ_ST);
      case (win)
        REQ_IF: mem_addr <= if_addr;
        REQ_LD: mem_addr <= ld_addr;
        REQ_ST: begin
          mem_addr  <= st_addr;
          mem_wdata <= st_wdata;
        end
        default: ;
      endcase
    end
  end

  assign tag_in.valid = if_gnt | ld_gnt;
  assign tag_in.dest  = ld_gnt ? DEST_LD : DEST_IF;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .resetn   (resetn),
    .tag_in   (tag_in),
    .tag_last (tag_last)
  );

  assign if_rvalid = tag_last.valid & (tag_last.dest == DEST_IF);
  assign ld_rvalid = tag_last.valid & (tag_last.dest == DEST_LD);
  assign if_rdata  = mem_rdata;
  assign ld_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] perf_if_q, perf_ld_q, perf_st_q, perf_conf_q;
  logic        conflict;

  assign conflict = (if_req & ld_req) | (if_req & st_req) | (ld_req & st_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_if_q   <= '0;
      perf_ld_q   <= '0;
      perf_st_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (if_gnt && perf_if_q != 16'hFFFF)     perf_if_q   <= perf_if_q + 16'd1;
      if (ld_gnt && perf_ld_q != 16'hFFFF)     perf_ld_q   <= perf_ld_q + 16'd1;
      if (st_gnt && perf_st_q != 16'hFFFF)     perf_st_q   <= perf_st_q + 16'd1;
      if (conflict && perf_conf_q != 16'hFFFF) perf_conf_q <= perf_conf_q + 16'd1;
    end
  end

  assign perf_if_cnt   = perf_if_q;
  assign perf_ld_cnt   = perf_ld_q;
  assign perf_st_cnt   = perf_st_q;
  assign perf_conf_cnt = perf_conf_q;
`else
  assign perf_if_cnt   = '0;
  assign perf_ld_cnt   = '0;
  assign perf_st_cnt   = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule
